// File: rtl/delay_sync_pipe_pkg.sv
// rtl/delay_sync_pipe_pkg.sv - shared defaults and width helpers for delay_sync_pipe
//
// Purpose: default geometry, reset polarity and derived-width helpers
// shared by delay_sync_pipe and sync_edge_det.
package delay_sync_pipe_pkg;

    localparam int   DEF_WIDTH       = 32;
    localparam int   DEF_DEPTH       = 8;
    localparam int   DEF_SYNC_STAGES = 2;

    // Level of GlobalReset_n that holds the block in reset.
    localparam logic RESET_ACTIVE    = 1'b0;

    // Width of the delay select: must encode 0..DEPTH plus at least one
    // out-of-range value so an over-range request can be flagged.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

    // Width of the fill counter, which saturates at DEPTH.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_sync_pipe_sync_edge_det.sv
// rtl/delay_sync_pipe_sync_edge_det.sv - srdyi synchroniser with rising-edge detect
//
// Purpose: brings an asynchronous strobe into the clk domain and produces a
// one-cycle rise_o per low-to-high transition.
// Ports:
//   clk            system clock
//   GlobalReset_n  asynchronous active-low reset
//   async_i        asynchronous strobe input
//   rise_o         one-cycle pulse, high in the cycle after the edge reaches
//                  the last synchroniser stage
module sync_edge_det
    import delay_sync_pipe_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic GlobalReset_n,
    input  logic async_i,
    output logic rise_o
);

    localparam int LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // fill_q marks when the chain holds only post-reset samples. The detector
    // arms only after a genuine low has propagated through, so a strobe that
    // was already high across reset release never produces a rise.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (GlobalReset_n == RESET_ACTIVE) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= sync_q[LAST];
            if (fill_q[LAST] && !sync_q[LAST]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise_o = sync_q[LAST] & ~prev_q & armed_q;

endmodule

// File: rtl/delay_sync_pipe.sv
// rtl/delay_sync_pipe.sv - strobe-synchronised programmable delay line for sync words
//
// Purpose: captures sync_i on each synchronised srdyi rise into a DEPTH-entry
// delay line and presents the word captured dly_sel strobes earlier.
// Ports:
//   clk            system clock
//   GlobalReset_n  asynchronous active-low reset
//   clr            synchronous soft clear
//   srdyi          asynchronous sample-ready strobe
//   sync_i         sync word, stable while the strobe is pending
//   dly_sel        requested delay in strobes (0..DEPTH valid)
//   sync_o         delayed sync word
//   sync_vld       one-cycle pulse when sync_o carries a primed word
//   primed         delay line holds at least min(dly_sel, DEPTH) words
//   dly_err        sticky flag, dly_sel > DEPTH seen at a strobe
module delay_sync_pipe
    import delay_sync_pipe_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          GlobalReset_n,
    input  logic                          clr,
    input  logic                          srdyi,
    input  logic [WIDTH-1:0]              sync_i,
    input  logic [sel_width(DEPTH)-1:0]   dly_sel,
    output logic [WIDTH-1:0]              sync_o,
    output logic                          sync_vld,
    output logic                          primed,
    output logic                          dly_err
);

    localparam int              SELW      = sel_width(DEPTH);
    localparam int              CNTW      = cnt_width(DEPTH);
    localparam logic [SELW-1:0] DEPTH_SEL = SELW'(DEPTH);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

    logic                rise;
    logic                sel_over;
    logic [SELW-1:0]     d_eff;
    logic [SELW-1:0]     cnt_ext;
    logic [WIDTH-1:0]    tap;

    logic [WIDTH-1:0]    stage_q [DEPTH];
    logic [WIDTH-1:0]    stage_d [DEPTH];
    logic [CNTW-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]    sync_o_q, sync_o_d;
    logic                vld_q,    vld_d;
    logic                err_q,    err_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk           (clk),
        .GlobalReset_n (GlobalReset_n),
        .async_i       (srdyi),
        .rise_o        (rise)
    );

    // Over-range requests behave as the maximum delay.
    assign sel_over = (dly_sel > DEPTH_SEL);
    assign d_eff    = sel_over ? DEPTH_SEL : dly_sel;
    assign cnt_ext  = SELW'(cnt_q);

    // Delay 0 passes the incoming word straight through; delay d selects the
    // word captured d strobes ago, i.e. pre-shift entry d-1.
    always_comb begin
        tap = sync_i;
        for (int i = 0; i < DEPTH; i++) begin
            if (d_eff == SELW'(i + 1)) begin
                tap = stage_q[i];
            end
        end
    end

    // clr takes priority over a coincident rise so that strobe is dropped.
    always_comb begin
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        sync_o_d = sync_o_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            cnt_d    = '0;
            sync_o_d = '0;
            err_d    = 1'b0;
        end else if (rise) begin
            stage_d[0] = sync_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            sync_o_d = tap;
            if (cnt_q != DEPTH_CNT) begin
                cnt_d = cnt_q + CNTW'(1);
            end
            vld_d = (cnt_ext >= d_eff);
            if (sel_over) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (GlobalReset_n == RESET_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            cnt_q    <= '0;
            sync_o_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            cnt_q    <= cnt_d;
            sync_o_q <= sync_o_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // primed tracks the live selection so a new dly_sel is reflected at once.
    assign primed   = (cnt_ext >= d_eff);
    assign sync_o   = sync_o_q;
    assign sync_vld = vld_q;
    assign dly_err  = err_q;

endmodule

// File: tb/tb_delay_sync_pipe.sv
// tb/tb_delay_sync_pipe.sv - self-checking bench for delay_sync_pipe
module tb_delay_sync_pipe;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int SELW        = 5;

    logic             clk = 1'b0;
    logic             GlobalReset_n;
    logic             clr;
    logic             srdyi;
    logic [WIDTH-1:0] sync_i;
    logic [SELW-1:0]  dly_sel;
    logic [WIDTH-1:0] sync_o;
    logic             sync_vld;
    logic             primed;
    logic             dly_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: hist[0] is the most recently captured word.
    logic [WIDTH-1:0] hist[$];
    bit               m_err;
    logic [WIDTH-1:0] m_out;

    always #5 clk = ~clk;

    delay_sync_pipe #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .GlobalReset_n (GlobalReset_n),
        .clr           (clr),
        .srdyi         (srdyi),
        .sync_i        (sync_i),
        .dly_sel       (dly_sel),
        .sync_o        (sync_o),
        .sync_vld      (sync_vld),
        .primed        (primed),
        .dly_err       (dly_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int sel);
        return (sel > DEPTH) ? DEPTH : sel;
    endfunction

    function automatic bit m_primed(input int sel);
        return hist.size() >= eff(sel);
    endfunction

    task automatic model_clear();
        hist.delete();
        m_err = 1'b0;
        m_out = '0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    // One strobe: srdyi high for `hold` cycles (or left high), optional clr
    // placed in the rise cycle. All vld pulses in the window are counted.
    task automatic strobe(input logic [WIDTH-1:0] w, input int sel, input int hold,
                          input bit clr_rise, input bit keep_high);
        int               d;
        int               nv;
        int               at;
        bit               ev;
        logic [WIDTH-1:0] ew;
        logic [WIDTH-1:0] seen;
        d  = eff(sel);
        ev = !clr_rise && (hist.size() >= d);
        if (d == 0)                ew = w;
        else if (d <= hist.size()) ew = hist[d-1];
        else                       ew = '0;
        @(negedge clk);
        sync_i  = w;
        dly_sel = SELW'(sel);
        srdyi   = 1'b1;
        nv = 0; at = 0; seen = '0;
        for (int i = 1; i <= hold + 6; i++) begin
            @(negedge clk);
            if (sync_vld) begin
                nv++;
                at   = i;
                seen = sync_o;
            end
            if (clr_rise && i == 2) clr = 1'b1;
            if (clr_rise && i == 3) clr = 1'b0;
            if (i == hold && !keep_high) srdyi = 1'b0;
        end
        if (clr_rise) begin
            model_clear();
        end else begin
            if (sel > DEPTH) m_err = 1'b1;
            m_out = ew;
            hist.push_front(w);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        check("vld_count", 64'(nv), ev ? 64'd1 : 64'd0);
        if (ev) begin
            check("vld_latency", 64'(at), 64'(SYNC_STAGES + 1));
            check("vld_word", 64'(seen), 64'(ew));
        end
        check("sync_o", 64'(sync_o), 64'(m_out));
        check("primed", 64'(primed), 64'(m_primed(sel)));
        check("dly_err", 64'(dly_err), 64'(m_err));
    endtask

    initial begin
        int nv;
        GlobalReset_n = 1'b0;
        clr     = 1'b0;
        srdyi   = 1'b0;
        sync_i  = '0;
        dly_sel = SELW'(3);
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_sync_o", 64'(sync_o), 64'd0);
        check("rst_vld", 64'(sync_vld), 64'd0);
        check("rst_err", 64'(dly_err), 64'd0);
        check("rst_primed_sel3", 64'(primed), 64'd0);
        dly_sel = '0;
        #1;
        check("rst_primed_sel0", 64'(primed), 64'd1);
        @(negedge clk);
        GlobalReset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Pass-through
        strobe(32'hA5A5_0001, 0, 3, 1'b0, 1'b0);

        // Delay 3 with words 1..5
        do_clr();
        for (int k = 1; k <= 5; k++) strobe(32'(k), 3, 3, 1'b0, 1'b0);

        // Maximum delay, counter saturation
        do_clr();
        for (int k = 0; k < 12; k++) strobe(32'h10 + 32'(k), DEPTH, 3, 1'b0, 1'b0);

        // Over-range select, sticky error, clear
        strobe(32'h99, 9, 3, 1'b0, 1'b0);
        strobe(32'h9A, 2, 3, 1'b0, 1'b0);
        do_clr();
        #1;
        check("clr_err", 64'(dly_err), 64'd0);
        check("clr_sync_o", 64'(sync_o), 64'd0);
        check("clr_primed", 64'(primed), 64'd0);

        // clr coincident with rise, then pass-through
        strobe(32'hDEAD, 1, 3, 1'b1, 1'b0);
        strobe(32'hBEEF, 0, 3, 1'b0, 1'b0);

        // Long hold produces a single pulse
        strobe(32'h66, 1, 20, 1'b0, 1'b0);

        // Reset while srdyi is held high
        strobe(32'h77, 0, 3, 1'b0, 1'b1);
        @(negedge clk);
        GlobalReset_n = 1'b0;
        #2;
        check("midrst_sync_o", 64'(sync_o), 64'd0);
        check("midrst_vld", 64'(sync_vld), 64'd0);
        model_clear();
        @(negedge clk);
        GlobalReset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sync_vld) nv++;
        end
        check("held_high_no_rise", 64'(nv), 64'd0);
        srdyi = 1'b0;
        repeat (5) @(negedge clk);
        strobe(32'h88, 0, 3, 1'b0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) do_clr();
            strobe($urandom, sel, int'($urandom_range(3, 6)),
                   $urandom_range(0, 11) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
